// File: rtl/roubus_axi_pkg.sv
// Shared AXI definitions for the roubus fabric: burst and response
// encodings, default AW attributes, write-channel state type and a
// descriptor legality check.
package roubus_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Normal non-cacheable bufferable; unprivileged, secure, data access.
  localparam logic [3:0] AWCACHE_DEF = 4'b0011;
  localparam logic [2:0] AWPROT_DEF  = 3'b000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DATA = 1'b1
  } wstate_e;

  // A descriptor is illegal on a 128-bit bus when the beat size exceeds
  // 16 bytes, the burst type is reserved, or a WRAP length is not 2/4/8/16.
  function automatic logic cmd_is_illegal(input logic [2:0] size,
                                          input logic [1:0] burst,
                                          input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > 3'd4) || (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_write_master.sv
// AXI4 write initiator. Takes one burst descriptor per command plus an
// in-order local beat stream and drives AW/W/B toward a write slave.
// Handshake rule on every channel: a transfer happens in the cycle where
// valid and ready are both high; a valid, once raised, holds its payload
// stable until that cycle.
module axi_write_master
  import roubus_axi_pkg::*;
#(
  parameter int IDWID  = 8,
  parameter int MAXOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  // command
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [7:0]       cmd_len,
  input  logic [2:0]       cmd_size,
  input  logic [1:0]       cmd_burst,
  input  logic [IDWID-1:0] cmd_id,
  // local beat stream
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [127:0]     wr_data,
  input  logic [15:0]      wr_strb,
  // AW channel
  output logic [IDWID-1:0] awid,
  output logic [31:0]      awaddr,
  output logic [7:0]       awlen,
  output logic [2:0]       awsize,
  output logic [1:0]       awburst,
  output logic [3:0]       awcache,
  output logic [2:0]       awprot,
  output logic             awvalid,
  input  logic             awready,
  // W channel
  output logic [127:0]     wdata,
  output logic [15:0]      wstrb,
  output logic             wlast,
  output logic             wvalid,
  input  logic             wready,
  // B channel
  input  logic [IDWID-1:0] bid,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready,
  // completion and status
  output logic             done_valid,
  output logic [IDWID-1:0] done_id,
  output logic             done_error,
  output logic             illegal_cmd,
  output logic [3:0]       outstanding,
  output logic             active
);

  localparam logic [3:0] MAXOUT_L = 4'(MAXOUT);

  wstate_e    wstate;
  logic [7:0] beat_cnt;
  logic       cmd_acc;
  logic       w_hs;
  logic       aw_hs;
  logic       b_hs;

  // The next command waits for the AW handshake and the last W beat, and
  // for a free slot in the outstanding window.
  assign cmd_ready = (wstate == IDLE) && !awvalid && (outstanding < MAXOUT_L);
  assign cmd_acc   = cmd_valid && cmd_ready;

  // W is a pure pass-through of the local stream while a burst is open.
  assign wvalid   = (wstate == DATA) && wr_valid;
  assign wr_ready = (wstate == DATA) && wready;
  assign wdata    = wr_data;
  assign wstrb    = wr_strb;
  assign wlast    = (wstate == DATA) && (beat_cnt == 8'd0);

  assign w_hs  = wvalid && wready;
  assign aw_hs = awvalid && awready;
  assign bready = (outstanding != 4'd0);
  assign b_hs  = bvalid && bready;

  assign awcache = AWCACHE_DEF;
  assign awprot  = AWPROT_DEF;
  assign active  = (wstate != IDLE) || (outstanding != 4'd0);

  // AW register: capture the descriptor on accept, hold until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awvalid <= 1'b0;
      awid    <= '0;
      awaddr  <= '0;
      awlen   <= '0;
      awsize  <= '0;
      awburst <= '0;
    end else if (cmd_acc) begin
      awvalid <= 1'b1;
      awid    <= cmd_id;
      awaddr  <= cmd_addr;
      awlen   <= cmd_len;
      awsize  <= cmd_size;
      awburst <= cmd_burst;
    end else if (aw_hs) begin
      awvalid <= 1'b0;
    end
  end

  // Write-data FSM: opens on accept, counts beats down, closes on wlast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate   <= IDLE;
      beat_cnt <= '0;
    end else begin
      case (wstate)
        IDLE: if (cmd_acc) begin
          wstate   <= DATA;
          beat_cnt <= cmd_len;
        end
        DATA: if (w_hs) begin
          if (beat_cnt == 8'd0) wstate <= IDLE;
          else                  beat_cnt <= beat_cnt - 8'd1;
        end
        default: wstate <= IDLE;
      endcase
    end
  end

  // Outstanding-burst counter; simultaneous issue and response cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (cmd_acc && !b_hs) begin
      outstanding <= outstanding + 4'd1;
    end else if (b_hs && !cmd_acc) begin
      outstanding <= outstanding - 4'd1;
    end
  end

  // One-cycle completion pulse per accepted B response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_valid <= 1'b0;
      done_id    <= '0;
      done_error <= 1'b0;
    end else begin
      done_valid <= b_hs;
      if (b_hs) begin
        done_id    <= bid;
        done_error <= bresp[1];
      end
    end
  end

  // Sticky illegal-descriptor flag; the command is issued regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cmd <= 1'b0;
    end else if (cmd_acc && cmd_is_illegal(cmd_size, cmd_burst, cmd_len)) begin
      illegal_cmd <= 1'b1;
    end
  end

endmodule
